grad_diff_pipe: RTL and testbench
=================================

# grad_diff_pipe

Two-stage pipelined signed difference unit for the edge-detection datapath, the subtracting counterpart of the signed pixel adder. It accepts a pair of signed samples per handshake and produces a (W+1)-bit difference `a - b` without overflow. It sits between the pixel-window buffer and the gradient-magnitude combiner. Valid/ready flow control on both sides supports full throughput and back-pressure.

## Interface
- `DATA_W`, 4: width of each signed input sample.
- `CNT_W`, 16: width of the completed-result counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input pair present.
- `in_ready`  out  1  unit accepts the pair this cycle.
- `in_a`  in  DATA_W  signed minuend.
- `in_b`  in  DATA_W  signed subtrahend.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result this cycle.
- `out_diff`  out  DATA_W+1  result; signed difference, or magnitude (see Configuration).
- `out_neg`  out  1  result sign: 1 when `a < b`. Valid with `out_valid`.
- `out_count`  out  CNT_W  number of results consumed since reset.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1):
  - Registers `in_a`, `in_b` and `s1_valid`.
  - `s1_adv = !s2_valid || out_ready`.
  - `in_ready = !s1_valid || s1_adv`. This is combinational and has no dependency on `in_valid`.
- Stage 2 (S2):
  - When `s1_adv` is true, loads `s2_valid <= s1_valid`.
  - When `s1_adv && s1_valid`, also loads the sign-extended `a - b` computed at DATA_W+1 bits, plus the sign.
  - When `s1_adv` is false, all S2 fields hold.
- Output drive: `out_valid = s2_valid`, and `out_diff` and `out_neg` are driven directly from S2 registers.
- Arithmetic:
  - Both operands are sign-extended to DATA_W+1 before subtracting, so overflow is impossible.
  - Range for DATA_W=4 is −15..+15.
- Counter:
  - `out_count` increments by 1 on each output transfer.
  - It wraps from 2^CNT_W−1 to 0 with no flag.
- Stage clearing:
  - When S1 advances and no input is transferred, `s1_valid` clears.
  - When S2 transfers out and S1 is empty, `s2_valid` clears.
- Stalls:
  - Output data must stay stable while `out_valid && !out_ready`.
  - Input data is ignored when `in_ready=0`.

## Timing
- Reset values: `s1_valid=0`, `s2_valid=0`, `out_valid=0`, `out_diff=0`, `out_neg=0`, `out_count=0`. `in_ready` is 1 on the first cycle after reset.
- Latency: a pair accepted at edge N appears with `out_valid=1` after edge N+1. That is 2 cycles, counted from input accept to first output-visible cycle.
- Throughput: one pair per cycle while `out_ready=1` is held.
- Back-pressure:
  - With `out_ready=0`, S2 and then S1 fill.
  - `in_ready` drops in the cycle where both stages are valid.
  - At most 2 results are buffered.
- Back-pressure release: when `out_ready` rises with both stages full, the output transfer, the S1→S2 move and a new input accept all happen on the same edge.
- Reset during operation: asserting `rst` discards both stages on the next edge with no output transfer, and clears `out_count`.

## Configuration
- `GRAD_ABS_EN` defined:
  - `out_diff` carries |a − b| as unsigned DATA_W+1.
  - The most-negative case −8 − 7 = −15 gives 15, and a − b = −(2^DATA_W) never occurs.
  - `out_neg` still reports the original sign.
- `GRAD_ABS_EN` undefined:
  - `out_diff` is the two's-complement signed difference.
  - `out_neg` equals `out_diff[DATA_W]`.
- Latency and handshake behaviour are identical in both builds.

## Structure
- Package `grad_pkg`:
  - Holds `DATA_W_DEFAULT = 4` and `CNT_W_DEFAULT = 16`.
  - Holds typedef `diff_t` (signed logic [DATA_W:0]), reused by the magnitude combiner.
- Sub-module `grad_pipe_stage`:
  - A parameterised valid/ready register slice containing a data register, a valid flag and advance logic.
  - Instantiated twice: S1 holds {a, b}, S2 holds {diff, neg}.
  - The subtract/abs logic is combinational between the two instances in the top level.

## Test plan
- Reset then single pair a=−6, b=−6 with `out_ready=1` → 2 cycles later `out_valid=1`, `out_diff=0`, `out_neg=0`, `out_count` increments to 1 on the transfer.
- Extremes a=7, b=−8 → `out_diff=15`. Then a=−8, b=7 → `out_diff=−15` (5'b10001) with `out_neg=1`, or 15 with `GRAD_ABS_EN`.
- Streaming of 8 back-to-back pairs with `out_ready=1` → 8 consecutive results, `in_ready` never low, `out_count=8`.
- Back-pressure: hold `out_ready=0`, offer 3 pairs → 2 accepted, `in_ready=0` on the third, `out_diff` stable. Release → all 3 emerge in order with no loss or duplication.
- `rst` asserted with both stages full → next cycle `out_valid=0`, `out_count=0`, `in_ready=1`. A subsequent pair yields a correct result after 2 cycles.
- Counter wrap with CNT_W=3: 9 results → `out_count` reads 1.

Source files
------------

// File: rtl/grad_pkg.sv
// Shared widths and the signed difference type for the gradient datapath.
// The GRAD_ABS_EN build option is handled in grad_diff_pipe.
package grad_pkg;

  localparam int DATA_W_DEFAULT = 4;
  localparam int CNT_W_DEFAULT  = 16;

  // One bit wider than a sample so a - b can never overflow.
  typedef logic signed [DATA_W_DEFAULT:0] diff_t;

endpackage

// File: rtl/grad_pipe_stage.sv
// Valid/ready register slice: one data register and one valid flag.
// The slice accepts new data whenever it is empty or its content is leaving.
module grad_pipe_stage
  import grad_pkg::*;
#(
  parameter int W = 2 * DATA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  // Data only loads on a real transfer, so it holds through stalls and bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/grad_diff_pipe.sv
// Two-stage pipelined signed difference a - b with valid/ready flow control.
// Define GRAD_ABS_EN to output |a - b| instead of the signed difference.
module grad_diff_pipe
  import grad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_diff,
  output logic              out_neg,
  output logic [CNT_W-1:0]  out_count
);

  logic                  s1_valid;
  logic                  s1_adv;
  logic [2*DATA_W-1:0]   s1_data;
  logic [DATA_W-1:0]     s1_a;
  logic [DATA_W-1:0]     s1_b;
  logic signed [DATA_W:0] a_ext;
  logic signed [DATA_W:0] b_ext;
  logic signed [DATA_W:0] diff;
  logic [DATA_W:0]       result;
  logic                  neg;
  logic [DATA_W+1:0]     s2_data;

  grad_pipe_stage #(.W(2 * DATA_W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .up_data  ({in_a, in_b}),
    .dn_valid (s1_valid),
    .dn_ready (s1_adv),
    .dn_data  (s1_data)
  );

  assign s1_a = s1_data[2*DATA_W-1:DATA_W];
  assign s1_b = s1_data[DATA_W-1:0];

  // Sign-extend both operands first; the extra bit absorbs the full range.
  always_comb begin
    a_ext = $signed({s1_a[DATA_W-1], s1_a});
    b_ext = $signed({s1_b[DATA_W-1], s1_b});
    diff  = a_ext - b_ext;
    neg   = diff[DATA_W];
`ifdef GRAD_ABS_EN
    result = neg ? 
      (DATA_W + 1)'(-diff) : (DATA_W + 1)'(diff);
`else
    result = (DATA_W + 1)'(diff);
`endif
  end

  grad_pipe_stage #(.W(DATA_W + 2)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s1_valid),
    .up_ready (s1_adv),
    .up_data  ({result, neg}),
    .dn_valid (out_valid),
    .dn_ready (out_ready),
    .dn_data  (s2_data)
  );

  assign out_diff = s2_data[DATA_W+1:1];
  assign out_neg  = s2_data[0];

  // Counts consumed results; wraps silently at the top of its range.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_grad_diff_pipe.sv
// Self-checking bench for grad_diff_pipe: table vectors, directed corner
// sequences and randomized traffic against a transaction-level queue model.
module tb_grad_diff_pipe;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_ready;

  logic          in_ready;
  logic          out_valid;
  logic [DW:0]   out_diff;
  logic          out_neg;
  logic [15:0]   out_count;

  logic          in_ready_s;
  logic          out_valid_s;
  logic [DW:0]   out_diff_s;
  logic          out_neg_s;
  logic [2:0]    out_count_s;

  grad_diff_pipe #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_neg(out_neg), .out_count(out_count)
  );

  grad_diff_pipe #(.DATA_W(DW), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_diff(out_diff_s), .out_neg(out_neg_s), .out_count(out_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW:0] diff;
    logic        neg;
    int          age;
  } item_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   diffSigned;
    logic [DW:0]   diffAbs;
    logic          neg;
  } vec_t;

  item_t q[$];
  int    modelCount;
  int    compareCount;
  int    failCount;
  vec_t  vec[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results leave in order; an item is visible one edge after entry.
  function automatic logic expOutValid();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  function automatic logic expInReady(input logic ordy);
    return (q.size() < 2) || ordy;
  endfunction

  function automatic item_t makeItem(input logic [DW-1:0] a, input logic [DW-1:0] b);
    item_t it;
    int d;
    d = int'($signed(a)) - int'($signed(b));
    it.neg = (d < 0);
`ifdef GRAD_ABS_EN
    it.diff = (DW + 1)'((d < 0) ? -d : d);
`else
    it.diff = (DW + 1)'(d);
`endif
    it.age = 0;
    return it;
  endfunction

  task automatic checkOutput();
    chk("in_ready", 32'(in_ready), 32'(expInReady(out_ready)));
    chk("out_valid", 32'(out_valid), 32'(expOutValid()));
    chk("out_count", 32'(out_count), 32'(modelCount % 65536));
    chk("in_ready_small", 32'(in_ready_s), 32'(expInReady(out_ready)));
    chk("out_count_small", 32'(out_count_s), 32'(modelCount % 8));
    if (expOutValid()) begin
      chk("out_diff", 32'(out_diff), 32'(q[0].diff));
      chk("out_neg", 32'(out_neg), 32'(q[0].neg));
      chk("out_diff_small", 32'(out_diff_s), 32'(q[0].diff));
    end
  endtask

  // Called at a negedge: check, drive, advance the model across the edge, return at next negedge.
  task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic ordy);
    logic inFire;
    logic outFire;
    checkOutput();
    rst       = r;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    outFire = expOutValid() && ordy;
    inFire  = v && expInReady(ordy);
    if (r) begin
      q.delete();
      modelCount = 0;
    end else begin
      if (outFire) begin
        void'(q.pop_front());
        modelCount++;
      end
      foreach (q[i]) q[i].age++;
      if (inFire) q.push_back(makeItem(a, b));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, ordy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    modelCount   = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

    vec[0] = '{4'hA, 4'hA, 5'h00, 5'h00, 1'b0};
    vec[1] = '{4'h7, 4'h8, 5'h0F, 5'h0F, 1'b0};
    vec[2] = '{4'h8, 4'h7, 5'h11, 5'h0F, 1'b1};
    vec[3] = '{4'h3, 4'h5, 5'h1E, 5'h02, 1'b1};
    vec[4] = '{4'h0, 4'h0, 5'h00, 5'h00, 1'b0};
    vec[5] = '{4'hF, 4'h8, 5'h07, 5'h07, 1'b0};
    vec[6] = '{4'h5, 4'hD, 5'h08, 5'h08, 1'b0};
    vec[7] = '{4'h8, 4'h8, 5'h00, 5'h00, 1'b0};
    vec[8] = '{4'h7, 4'h7, 5'h00, 5'h00, 1'b0};
    vec[9] = '{4'h8, 4'h0, 5'h18, 5'h08, 1'b1};

    @(posedge clk);
    @(negedge clk);
    doReset();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_diff", 32'(out_diff), 32'd0);
    chk("reset_out_neg", 32'(out_neg), 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Single pairs: accepted on one edge, visible after the next.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, vec[i].a, vec[i].b, 1'b1);
      chk("vec_not_early", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      chk("vec_valid", 32'(out_valid), 32'd1);
`ifdef GRAD_ABS_EN
      chk("vec_diff", 32'(out_diff), 32'(vec[i].diffAbs));
`else
      chk("vec_diff", 32'(out_diff), 32'(vec[i].diffSigned));
`endif
      chk("vec_neg", 32'(out_neg), 32'(vec[i].neg));
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      chk("vec_count", 32'(out_count), 32'(i + 1));
    end

    // Streaming eight back-to-back pairs.
    doReset();
    for (int i = 0; i < 8; i++) begin
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
    end
    idle(3, 1'b1);
    chk("stream_count", 32'(out_count), 32'd8);

    // Back-pressure: two buffered, third refused, then release.
    doReset();
    applyStimulus(1'b0, 1'b1, 4'h3, 4'h1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h9, 4'h2, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'h6, 4'hC, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h6, 4'hC, 1'b0);
    chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'h6, 4'hC, 1'b1);
    idle(4, 1'b1);
    chk("bp_count", 32'(out_count), 32'd3);

    // Reset with both stages full.
    applyStimulus(1'b0, 1'b1, 4'h2, 4'h4, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h1, 4'h7, 1'b0);
    doReset();
    chk("rst_full_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full_count", 32'(out_count), 32'd0);
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'h1, 4'hE, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rst_after_valid", 32'(out_valid), 32'd1);
    chk("rst_after_diff", 32'(out_diff), 32'd3);

    // Counter wrap on the 3-bit instance.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'b1);
    idle(3, 1'b1);
    chk("wrap_small_count", 32'(out_count_s), 32'd1);
    chk("wrap_big_count", 32'(out_count), 32'd9);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom),
                    4'($urandom), ($urandom_range(0, 3) != 0));
      rst = 1'b0;
    end
    idle(4, 1'b1);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
